// File: rtl/edge_detect_sync_pkg.sv
// Shared types and sizing helpers for the multi-channel synchronising edge detector.
package edge_det_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  // Debounce counter width: enough to hold FILT_CYCLES-1, never narrower than one bit.
  function automatic int cnt_width(input int filt);
    return ($clog2(filt + 1) < 1) ? 1 : $clog2(filt + 1);
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: async-input synchroniser, glitch filter, mode-qualified edge pulses, sticky flag.
module edge_chan
  import edge_det_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CYCLES = 0,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sig,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic       flag
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   update;
  logic                   rise_nxt;
  logic                   fall_nxt;
  edge_mode_t             mode_e;

  assign s = sync[SYNC_STAGES-1];

  // NOTE: rst_n is tested inside the clocked block, so reset is synchronous to clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      // NOTE: non-blocking assignments let every stage shift on the same edge.
      sync <= {sync[SYNC_STAGES-2:0], sig};
    end
  end

  if (FILT_CYCLES == 0) begin : g_bypass
    assign update = (s != level);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        level <= RST_VAL;
      end else begin
        level <= s;
      end
    end
  end else begin : g_filt
    localparam int            CW   = cnt_width(FILT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(FILT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // The level flips on the edge where the differing run reaches FILT_CYCLES samples.
    assign update = (s != level) && (cnt == LAST);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt   <= '0;
        level <= RST_VAL;
      end else if (s == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Mode is looked at only at the update edge; a mid-filter change does not disturb the count.
  assign mode_e   = edge_mode_t'(mode);
  assign rise_nxt = update &  s & ((mode_e == EDGE_RISE) || (mode_e == EDGE_BOTH));
  assign fall_nxt = update & ~s & ((mode_e == EDGE_FALL) || (mode_e == EDGE_BOTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
      flag <= 1'b0;
    end else begin
      rise <= rise_nxt;
      fall <= fall_nxt;
      // Set beats clear so an event arriving with a clear is never lost.
      flag <= (flag & ~clr) | rise_nxt | fall_nxt;
    end
  end

endmodule

// File: rtl/edge_detect_sync.sv
// N_CH independent synchronising edge detectors plus a global sticky-flag summary.
module edge_detect_sync
  import edge_det_pkg::*;
#(
  parameter int              N_CH        = 4,
  parameter int              SYNC_STAGES = 2,
  parameter int              FILT_CYCLES = 0,
  parameter logic [N_CH-1:0] RST_VAL     = {N_CH{1'b0}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     sig_i,
  input  logic [2*N_CH-1:0]   mode_i,
  input  logic [N_CH-1:0]     clr_i,
  output logic [N_CH-1:0]     level_o,
  output logic [N_CH-1:0]     rise_o,
  output logic [N_CH-1:0]     fall_o,
  output logic [N_CH-1:0]     edge_o,
  output logic [N_CH-1:0]     flag_o,
  output logic                any_flag_o
);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES),
      .RST_VAL     (RST_VAL[c])
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .sig   (sig_i[c]),
      .mode  (mode_i[2*c+1:2*c]),
      .clr   (clr_i[c]),
      .level (level_o[c]),
      .rise  (rise_o[c]),
      .fall  (fall_o[c]),
      .flag  (flag_o[c])
    );
  end

  assign edge_o     = rise_o | fall_o;
  assign any_flag_o = |flag_o;

endmodule

// File: tb/tb_edge_detect_sync.sv
// Checks a filtered (FILT_CYCLES=3) and a bypass (FILT_CYCLES=0) build against a sample-history model.
module tb_edge_detect_sync;
  import edge_det_pkg::*;

  localparam int N = 4;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   sig;
  logic [2*N-1:0] mode;
  logic [N-1:0]   clr;

  logic [N-1:0] level_f, rise_f, fall_f, edge_f, flag_f;
  logic [N-1:0] level_b, rise_b, fall_b, edge_b, flag_b;
  logic         any_f, any_b;

  edge_detect_sync #(.N_CH(N), .SYNC_STAGES(S), .FILT_CYCLES(3), .RST_VAL(4'h0)) dut (
    .clk(clk), .rst_n(rst_n), .sig_i(sig), .mode_i(mode), .clr_i(clr),
    .level_o(level_f), .rise_o(rise_f), .fall_o(fall_f), .edge_o(edge_f),
    .flag_o(flag_f), .any_flag_o(any_f)
  );

  edge_detect_sync #(.N_CH(N), .SYNC_STAGES(S), .FILT_CYCLES(0), .RST_VAL(4'h0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sig_i(sig), .mode_i(mode), .clr_i(clr),
    .level_o(level_b), .rise_o(rise_b), .fall_o(fall_b), .edge_o(edge_b),
    .flag_o(flag_b), .any_flag_o(any_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: each channel sees its input delayed by S samples; a filtered level flips once the
  // delayed input has disagreed with it for max(F,1) consecutive samples.
  int   filt [2] = '{3, 0};
  logic q [N][$];
  logic m_level [2][N];
  logic m_rise  [2][N];
  logic m_fall  [2][N];
  logic m_flag  [2][N];
  int   m_run   [2][N];

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      q[c].delete();
      for (int k = 0; k < S; k++) q[c].push_back(1'b0);
      for (int b = 0; b < 2; b++) begin
        m_level[b][c] = 1'b0;
        m_rise[b][c]  = 1'b0;
        m_fall[b][c]  = 1'b0;
        m_flag[b][c]  = 1'b0;
        m_run[b][c]   = 0;
      end
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int c = 0; c < N; c++) begin
      logic s;
      s = q[c].pop_front();
      q[c].push_back(sig[c]);
      for (int b = 0; b < 2; b++) begin
        int   lim;
        logic changed;
        lim     = (filt[b] == 0) ? 1 : filt[b];
        changed = 1'b0;
        if (s == m_level[b][c]) begin
          m_run[b][c] = 0;
        end else begin
          m_run[b][c]++;
          if (m_run[b][c] == lim) begin
            m_level[b][c] = s;
            m_run[b][c]   = 0;
            changed       = 1'b1;
          end
        end
        m_rise[b][c] = changed &  s & mode[2*c];
        m_fall[b][c] = changed & ~s & mode[2*c+1];
        m_flag[b][c] = (m_flag[b][c] & ~clr[c]) | m_rise[b][c] | m_fall[b][c];
      end
    end
  endtask

  task automatic compare();
    for (int b = 0; b < 2; b++) begin
      logic [N-1:0] lv, rv, fv, gv;
      for (int c = 0; c < N; c++) begin
        lv[c] = m_level[b][c];
        rv[c] = m_rise[b][c];
        fv[c] = m_fall[b][c];
        gv[c] = m_flag[b][c];
      end
      check($sformatf("b%0d_level", b), 32'(b == 0 ? level_f : level_b), 32'(lv));
      check($sformatf("b%0d_rise", b),  32'(b == 0 ? rise_f  : rise_b),  32'(rv));
      check($sformatf("b%0d_fall", b),  32'(b == 0 ? fall_f  : fall_b),  32'(fv));
      check($sformatf("b%0d_edge", b),  32'(b == 0 ? edge_f  : edge_b),  32'(rv | fv));
      check($sformatf("b%0d_flag", b),  32'(b == 0 ? flag_f  : flag_b),  32'(gv));
      check($sformatf("b%0d_any", b),   32'(b == 0 ? any_f   : any_b),   32'(|gv));
    end
  endtask

  int cyc = 0;

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    compare();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_mode(input int c, input logic [1:0] m);
    mode[2*c +: 2] = m;
  endtask

  initial begin
    int t_rise, t_fall, n_edges, pulses;
    model_reset();
    rst_n = 1'b0;
    sig   = 4'hF;
    mode  = {N{EDGE_BOTH}};
    clr   = '0;

    // Reset with all inputs high: outputs stay clear, then every channel reports a rise.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_level", 32'(level_f), 32'h0);
      check("rst_flag",  32'(flag_f),  32'h0);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (e == 3) check("byp_rise_e3", 32'(rise_b), 32'hF);
      if (e == 4) check("filt_rise_e4", 32'(rise_f), 32'h0);
      if (e == 5) begin
        check("filt_rise_e5", 32'(rise_f), 32'hF);
        check("filt_flag_e5", 32'(flag_f), 32'hF);
      end
    end
    tick();
    check("rise_one_cycle", 32'(rise_f), 32'h0);

    sig = 4'h0;
    ticks(8);
    clr = 4'hF;
    tick();
    clr = 4'h0;
    check("flags_cleared", 32'(flag_f), 32'h0);

    // Clean rise on ch0 in rise-only mode.
    set_mode(0, EDGE_RISE);
    sig[0] = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (e == 5) check("ch0_rise_e5", 32'(rise_f), 32'h1);
    end
    ticks(3);
    check("ch0_level", 32'(level_f[0]), 32'h1);

    // Two-sample glitch on ch1 is swallowed; three samples gets through.
    sig[1] = 1'b1; ticks(2);
    sig[1] = 1'b0; ticks(8);
    check("ch1_glitch_level", 32'(level_f[1]), 32'h0);
    check("ch1_glitch_flag",  32'(flag_f[1]),  32'h0);
    sig[1] = 1'b1; ticks(3);
    sig[1] = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin tick(); pulses += int'(rise_f[1]); end
    check("ch1_three_rise", 32'(pulses), 32'd1);
    ticks(6);

    // ch2 in both mode: rise, hold ten cycles, fall.
    set_mode(2, EDGE_BOTH);
    t_rise = -1; t_fall = -1; n_edges = 0;
    sig[2] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) sig[2] = 1'b0;
      tick();
      if (edge_f[2]) n_edges++;
      if (rise_f[2]) t_rise = cyc;
      if (fall_f[2]) t_fall = cyc;
    end
    check("ch2_edges", 32'(n_edges), 32'd2);
    check("ch2_gap", 32'(t_fall - t_rise), 32'd10);

    // ch3 mode off tracks level silently; then clear racing the pulse loses to the set.
    clr = 4'hF; tick(); clr = 4'h0;
    set_mode(3, EDGE_OFF);
    sig[3] = 1'b1; ticks(6);
    check("ch3_off_level", 32'(level_f[3]), 32'h1);
    sig[3] = 1'b0; ticks(6);
    check("ch3_off_flag", 32'(flag_f[3]), 32'h0);
    set_mode(3, EDGE_RISE);
    sig[3] = 1'b1; ticks(4);
    clr[3] = 1'b1; tick();
    check("ch3_race_pulse", 32'(rise_f[3]), 32'h1);
    check("ch3_race_flag", 32'(flag_f[3]), 32'h1);
    tick();
    clr[3] = 1'b0;
    check("ch3_cleared", 32'(flag_f[3]), 32'h0);
    check("ch3_any", 32'(any_f), 32'(|flag_f));

    // Reset mid-filter on ch0 discards the partial transition.
    clr = 4'hF;
    sig = 4'h0; ticks(8);
    clr = 4'h0;
    sig[0] = 1'b1; ticks(4);
    rst_n  = 1'b0;
    sig[0] = 1'b0; ticks(2);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin tick(); pulses += int'(rise_f[0]); end
    check("midrst_pulses", 32'(pulses), 32'd0);
    check("midrst_level", 32'(level_f[0]), 32'h0);

    // Random phase: mostly-held inputs with occasional toggles, clears, mode changes, resets.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(3) == 0) sig[c] = ~sig[c];
      clr = ($urandom_range(7) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(49) == 0) mode = 8'($urandom);
      rst_n = ($urandom_range(499) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_detect_sync.md
Name: edge_detect_sync

Overview:
- Parametrised multi-channel successor to the single-signal rise-edge detector.
- Each channel does the following:
  - synchronises an asynchronous input through a configurable flop chain;
  - removes glitches with a per-channel debounce counter;
  - reports rise, fall or both edges as single-cycle pulses, selected per channel;
  - keeps a sticky event flag that software clears.
- Sits at the boundary between async inputs (buttons, byte strobes, external handshakes) and the core clock domain.

Parameters:
- N_CH, 4, number of independent channels.
- SYNC_STAGES, 2, synchroniser depth. Legal range 2..4.
- FILT_CYCLES, 0, consecutive cycles the synchronised value must differ before the filtered level changes. 0 = bypass.
- RST_VAL, {N_CH{1'b0}}, per-channel idle level loaded at reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low; clock clk.
- sig_i  in  N_CH  asynchronous input signals.
- mode_i  in  2*N_CH  per-channel edge select: 00 off, 01 rise, 10 fall, 11 both. Channel c uses bits [2c+1:2c].
- clr_i  in  N_CH  per-channel flag clear, active-high, level.
- level_o  out  N_CH  filtered, synchronised level.
- rise_o  out  N_CH  one-cycle pulse on a rising filtered edge, qualified by mode.
- fall_o  out  N_CH  one-cycle pulse on a falling filtered edge, qualified by mode.
- edge_o  out  N_CH  rise_o | fall_o.
- flag_o  out  N_CH  sticky event flags.
- any_flag_o  out  1  OR-reduction of flag_o (combinational).

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - sync chain and level_o load RST_VAL;
  - debounce counters load 0;
  - rise_o, fall_o, edge_o and flag_o load 0.
  - Reset overrides every other action in the same cycle.
- Synchroniser: sync[0] <= sig_i; sync[k] <= sync[k-1]. s = sync[SYNC_STAGES-1].
- Debounce when FILT_CYCLES=0: level <= s every cycle.
- Debounce when FILT_CYCLES>=1:
  - If s == level: cnt <= 0.
  - Else if cnt == FILT_CYCLES-1: level <= s and cnt <= 0.
  - Else: cnt <= cnt+1.
  - cnt width is $clog2(FILT_CYCLES+1), minimum 1. cnt never exceeds FILT_CYCLES-1.
- Glitches: a differing run shorter than max(FILT_CYCLES,1) synchronised cycles produces no level change and no pulse. The counter restarts on every return to level.
- Edge pulses:
  - Registered, asserted on the same clock edge at which level_o changes.
  - rise_o <= update & s & mode[0].
  - fall_o <= update & ~s & mode[1].
  - Pulses last exactly 1 cycle. There are no back-to-back pulses on one channel when FILT_CYCLES>=2.
- Latency: sig_i change (stable before edge 1) → level_o and pulse at edge SYNC_STAGES + max(FILT_CYCLES,1).
- Mode handling:
  - mode_i is sampled combinationally at the update edge and is not latched.
  - Mode 00 still tracks level_o but suppresses pulses and flags.
  - A mode change mid-filter does not restart the counter.
- Flags:
  - flag_o[c] <= (flag_o[c] & ~clr_i[c]) | edge(c).
  - If an edge and a clear occur in the same cycle, the set wins, so no event is lost.
  - Flags are set on the same edge as the pulse.
- Post-reset: if sig_i differs from RST_VAL, the edge is reported normally after the latency. This is intentional; integrators set RST_VAL to the idle level.
- Reset mid-filter: the partial count is discarded and no pulse is produced for the interrupted transition.
- Channels are fully independent. Simultaneous events on multiple channels all report in the same cycle.

Decomposition:
- Package edge_det_pkg:
  - typedef edge_mode_t (2-bit enum: EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH);
  - localparam helper for the counter width.
- Sub-module edge_chan:
  - one channel: sync chain, debounce counter, pulse and flag logic;
  - same parameters minus N_CH, with a scalar RST_VAL bit.
- Top edge_detect_sync: a generate loop over N_CH instances of edge_chan, plus the any_flag_o reduction.

Test Plan:
(All scenarios use N_CH=4, SYNC_STAGES=2, FILT_CYCLES=3, RST_VAL=0 unless stated.)
1. Reset: hold rst_n=0 for 3 cycles with sig_i=4'hF → all outputs 0 and level_o=0 during reset. After release, rise_o=4'hF (modes=both) at edge 5 after release, and flag_o=4'hF.
2. Clean rise on ch0: mode=01, sig_i[0] 0→1 before edge 1 → rise_o[0]=1 only at edge 5; level_o[0]=1 from edge 5; flag_o[0] set; fall_o=0.
3. Glitch on ch1: sig_i[1] high for 2 cycles then low → level_o[1] stays 0; no pulse; flag_o[1]=0. Repeat with 3 cycles high → rise pulse.
4. Both mode on ch2: rise, hold 10 cycles, fall → rise_o[2] pulse, then fall_o[2] pulse exactly 10 cycles later; edge_o[2] pulses twice.
5. Mode off and clear race on ch3:
   - mode=00, toggle sig → level_o[3] follows; no pulse; flag stays 0.
   - Then mode=01, assert clr_i[3] in the same cycle as the rise pulse → flag_o[3]=1 afterwards.
   - Clear alone next cycle → flag_o[3]=0; any_flag_o tracks.
6. Reset mid-filter: rise on ch0, assert rst_n=0 after 2 filter cycles, input returns low before release → no pulse, level_o[0]=0, counter restarted. Also FILT_CYCLES=0 build: latency = 3 edges.
